// File: rtl/riscv_run_monitor.sv
`default_nettype none
// ============================================================================
// Module      : riscv_run_monitor
// Description : Run controller and self-checker for RISC-V cores. Sequences
//               core reset, gates the core clock enable, counts run cycles,
//               detects program end (tohost store, PC self-loop or cycle
//               budget), then scans expected register values through a
//               register-file debug read port and reports pass/fail.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_run_monitor #(
  parameter int              XLEN          = 32,
  parameter int              NUM_CHECKS    = 8,
  parameter int              CYCLE_LIMIT   = 30,
  parameter int              RESET_HOLD    = 2,
  parameter int              HALT_REPEAT   = 2,
  parameter logic [XLEN-1:0] TOHOST_ADDR   = 32'h0000_0100,
  parameter bit              TIMEOUT_FAILS = 1'b0,
  localparam int             FAIL_W        = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
  localparam int             CNT_W         = $clog2(NUM_CHECKS + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     core_rst_n,
  output logic                     core_run,
  input  logic [XLEN-1:0]          pc,
  input  logic                     dmem_we,
  input  logic [XLEN-1:0]          dmem_addr,
  input  logic [XLEN-1:0]          dmem_wdata,
  input  logic [5*NUM_CHECKS-1:0]  exp_idx,
  input  logic [XLEN*NUM_CHECKS-1:0] exp_val,
  output logic [4:0]               rf_raddr,
  input  logic [XLEN-1:0]          rf_rdata,
  output logic                     done,
  output logic                     pass,
  output logic [1:0]               halt_cause,
  output logic [XLEN-1:0]          tohost_val,
  output logic [FAIL_W-1:0]        fail_idx,
  output logic [CNT_W-1:0]         mismatch_cnt,
  output logic [31:0]              cycle_count
);

  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam int SAME_W = $clog2(HALT_REPEAT + 1);

  localparam logic [HOLD_W-1:0] C_HOLD_LAST   = HOLD_W'(RESET_HOLD - 1);
  localparam logic [SAME_W-1:0] C_HALT_REPEAT = SAME_W'(HALT_REPEAT);
  localparam logic [31:0]       C_CYCLE_LAST  = 32'(CYCLE_LIMIT - 1);
  localparam logic [FAIL_W-1:0] C_CHK_LAST    = FAIL_W'(NUM_CHECKS - 1);
  localparam logic [1:0]        C_HC_TOHOST   = 2'b01;
  localparam logic [1:0]        C_HC_LOOP     = 2'b10;
  localparam logic [1:0]        C_HC_TIMEOUT  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HOLD  = 3'd1,
    S_RUN   = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic                r_core_rst_n;
  logic                r_core_run;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic                r_first_run;
  logic [XLEN-1:0]     r_prev_pc;
  logic [SAME_W-1:0]   r_same_cnt;
  logic [FAIL_W-1:0]   r_chk_idx;
  logic [4:0]          r_rf_raddr;
  logic                r_done;
  logic                r_pass;
  logic [1:0]          r_halt_cause;
  logic [XLEN-1:0]     r_tohost_val;
  logic [FAIL_W-1:0]   r_fail_idx;
  logic [CNT_W-1:0]    r_mismatch_cnt;
  logic [31:0]         r_cycle_count;

  logic [4:0]          w_idx_arr [NUM_CHECKS];
  logic [XLEN-1:0]     w_val_arr [NUM_CHECKS];
  logic [SAME_W-1:0]   w_same_nxt;
  logic                w_is_tohost;
  logic                w_is_loop;
  logic                w_is_timeout;
  logic                w_halt;
  logic                w_chk_last;
  logic                w_chk_miss;
  logic [FAIL_W-1:0]   w_chk_nxt;

  // Unpack the flat expectation vectors into per-check entries
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHECKS; gi++) begin : g_unpack
      assign w_idx_arr[gi] = exp_idx[5*gi +: 5];
      assign w_val_arr[gi] = exp_val[XLEN*gi +: XLEN];
    end
  endgenerate

  // Halt detection; the first RUN cycle has no previous PC to compare against
  assign w_is_tohost  = dmem_we && (dmem_addr == TOHOST_ADDR);
  assign w_same_nxt   = (!r_first_run && (pc == r_prev_pc)) ? (r_same_cnt + SAME_W'(1)) : '0;
  assign w_is_loop    = (w_same_nxt == C_HALT_REPEAT);
  assign w_is_timeout = (r_cycle_count == C_CYCLE_LAST);
  assign w_halt       = w_is_tohost || w_is_loop || w_is_timeout;

  assign w_chk_last   = (r_chk_idx == C_CHK_LAST);
  assign w_chk_miss   = (rf_rdata != w_val_arr[r_chk_idx]);
  assign w_chk_nxt    = r_chk_idx + FAIL_W'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; start is honoured only in IDLE and DONE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_HOLD;
      S_HOLD:  if (r_hold_cnt == C_HOLD_LAST) w_state_nxt = S_RUN;
      S_RUN:   if (w_halt) w_state_nxt = S_CHECK;
      S_CHECK: if (w_chk_last) w_state_nxt = S_DONE;
      S_DONE:  if (start) w_state_nxt = S_HOLD;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs, run counters and the register scan datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_core_rst_n   <= 1'b0;
      r_core_run     <= 1'b0;
      r_hold_cnt     <= '0;
      r_first_run    <= 1'b0;
      r_prev_pc      <= '0;
      r_same_cnt     <= '0;
      r_chk_idx      <= '0;
      r_rf_raddr     <= '0;
      r_done         <= 1'b0;
      r_pass         <= 1'b0;
      r_halt_cause   <= '0;
      r_tohost_val   <= '0;
      r_fail_idx     <= '0;
      r_mismatch_cnt <= '0;
      r_cycle_count  <= '0;
    end else begin
      // Core controls follow the state being entered so they switch on the same edge
      r_core_rst_n <= (w_state_nxt == S_RUN) || (w_state_nxt == S_CHECK) || (w_state_nxt == S_DONE);
      r_core_run   <= (w_state_nxt == S_RUN);

      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_state_nxt == S_HOLD) begin
            r_hold_cnt     <= '0;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
            r_halt_cause   <= '0;
            r_tohost_val   <= '0;
            r_fail_idx     <= '0;
            r_mismatch_cnt <= '0;
            r_cycle_count  <= '0;
            r_rf_raddr     <= '0;
          end else if (r_state == S_DONE) begin
            // Result is published one cycle after the final check settles the counters
            r_done <= 1'b1;
            r_pass <= (r_mismatch_cnt == '0) &&
                      !(TIMEOUT_FAILS && (r_halt_cause == C_HC_TIMEOUT));
          end
        end
        S_HOLD: begin
          r_hold_cnt  <= r_hold_cnt + HOLD_W'(1);
          r_first_run <= 1'b1;
          r_same_cnt  <= '0;
        end
        S_RUN: begin
          if (r_cycle_count != 32'hFFFF_FFFF) r_cycle_count <= r_cycle_count + 32'd1;
          r_first_run <= 1'b0;
          r_prev_pc   <= pc;
          r_same_cnt  <= w_same_nxt;
          if (w_halt) begin
            if (w_is_tohost) begin
              r_halt_cause <= C_HC_TOHOST;
              r_tohost_val <= dmem_wdata;
            end else if (w_is_loop) begin
              r_halt_cause <= C_HC_LOOP;
            end else begin
              r_halt_cause <= C_HC_TIMEOUT;
            end
            r_chk_idx  <= '0;
            r_rf_raddr <= w_idx_arr[0];
          end
        end
        S_CHECK: begin
          if (w_chk_miss) begin
            r_mismatch_cnt <= r_mismatch_cnt + CNT_W'(1);
            if (r_mismatch_cnt == '0) r_fail_idx <= r_chk_idx;
          end
          if (!w_chk_last) begin
            r_chk_idx  <= w_chk_nxt;
            r_rf_raddr <= w_idx_arr[w_chk_nxt];
          end
        end
        default: ;
      endcase
    end
  end

  assign core_rst_n   = r_core_rst_n;
  assign core_run     = r_core_run;
  assign rf_raddr     = r_rf_raddr;
  assign done         = r_done;
  assign pass         = r_pass;
  assign halt_cause   = r_halt_cause;
  assign tohost_val   = r_tohost_val;
  assign fail_idx     = r_fail_idx;
  assign mismatch_cnt = r_mismatch_cnt;
  assign cycle_count  = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_riscv_run_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_run_monitor
// Description : Scoreboard bench for riscv_run_monitor. A small scripted core
//               model drives PC and stores while core_run is high; expected
//               results are queued at start and checked when done rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_run_monitor;

  localparam int NC = 8;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] pc;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [5*NC-1:0]  exp_idx;
  logic [32*NC-1:0] exp_val;

  logic        core_rst_n, core_run, done, pass;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [1:0]  halt_cause;
  logic [31:0] tohost_val, cycle_count;
  logic [2:0]  fail_idx;
  logic [3:0]  mismatch_cnt;

  logic        core_rst_n_tf, core_run_tf, done_tf, pass_tf;
  logic [4:0]  rf_raddr_tf;
  logic [31:0] rf_rdata_tf;
  logic [1:0]  halt_cause_tf;
  logic [31:0] tohost_val_tf, cycle_count_tf;
  logic [2:0]  fail_idx_tf;
  logic [3:0]  mismatch_cnt_tf;

  logic [31:0] regs [32];
  assign rf_rdata    = regs[rf_raddr];
  assign rf_rdata_tf = regs[rf_raddr_tf];

  riscv_run_monitor #(.TIMEOUT_FAILS(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .core_rst_n(core_rst_n), .core_run(core_run),
    .pc(pc), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .exp_idx(exp_idx), .exp_val(exp_val),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .done(done), .pass(pass), .halt_cause(halt_cause), .tohost_val(tohost_val),
    .fail_idx(fail_idx), .mismatch_cnt(mismatch_cnt), .cycle_count(cycle_count)
  );

  riscv_run_monitor #(.TIMEOUT_FAILS(1'b1)) dut_tf (
    .clk(clk), .rst_n(rst_n), .start(start),
    .core_rst_n(core_rst_n_tf), .core_run(core_run_tf),
    .pc(pc), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .exp_idx(exp_idx), .exp_val(exp_val),
    .rf_raddr(rf_raddr_tf), .rf_rdata(rf_rdata_tf),
    .done(done_tf), .pass(pass_tf), .halt_cause(halt_cause_tf), .tohost_val(tohost_val_tf),
    .fail_idx(fail_idx_tf), .mismatch_cnt(mismatch_cnt_tf), .cycle_count(cycle_count_tf)
  );

  typedef struct {
    logic [1:0]  hc;
    logic [31:0] th;
    logic [31:0] cc;
    logic        ps;
    logic        ps_tf;
    logic [3:0]  mm;
    logic [2:0]  fi;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   start_edge = 0;
  int   n_run = 0;

  // scenario knobs for the core model
  int          store_cyc;
  logic [31:0] store_data;
  int          loop_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic [1:0] hc, input logic [31:0] th, input logic [31:0] cc,
                              input logic ps, input logic ps_tf, input logic [3:0] mm,
                              input logic [2:0] fi, input int lat);
    exp_t e;
    e.hc = hc; e.th = th; e.cc = cc; e.ps = ps; e.ps_tf = ps_tf; e.mm = mm; e.fi = fi; e.lat = lat;
    return e;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Core model: PC walks by 4 per run cycle (or sticks at the loop PC), with a
  // decoy store in cycle 3 and the tohost store in the scripted cycle
  initial begin
    pc = '0; dmem_we = 1'b0; dmem_addr = 32'h100; dmem_wdata = '0;
    forever begin
      @(negedge clk);
      if (!core_rst_n) begin
        n_run = 0; pc = '0; dmem_we = 1'b0;
      end else if (core_run) begin
        n_run++;
        pc = (loop_cyc != 0 && n_run >= loop_cyc) ? 32'h2C : 32'(4 * (n_run - 1));
        if (n_run == store_cyc) begin
          dmem_we = 1'b1; dmem_addr = 32'h100; dmem_wdata = store_data;
        end else if (n_run == 3) begin
          dmem_we = 1'b1; dmem_addr = 32'h104; dmem_wdata = 32'hDEAD;
        end else begin
          dmem_we = 1'b0; dmem_addr = 32'h100; dmem_wdata = 32'h55;
        end
      end else begin
        dmem_we = 1'b0;
      end
    end
  end

  // Monitor: compare queued expectation when done rises
  initial begin
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !prev_done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("halt_cause",   32'(halt_cause),   32'(e.hc));
          chk("tohost_val",   tohost_val,        e.th);
          chk("cycle_count",  cycle_count,       e.cc);
          chk("mismatch_cnt", 32'(mismatch_cnt), 32'(e.mm));
          chk("fail_idx",     32'(fail_idx),     32'(e.fi));
          chk("pass",         32'(pass),         32'(e.ps));
          chk("pass_tf",      32'(pass_tf),      32'(e.ps_tf));
          chk("done_tf",      32'(done_tf),      32'd1);
          chk("core_run_off", 32'(core_run),     32'd0);
          chk("latency",      32'(cyc - start_edge), 32'(e.lat));
        end
      end
      prev_done = done;
    end
  end

  task automatic run(input exp_t e);
    @(negedge clk);
    start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    start_edge = cyc;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    chk("done_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_core_rst_n"},   32'(core_rst_n),   32'd0);
    chk({tag, "_core_run"},     32'(core_run),     32'd0);
    chk({tag, "_done"},         32'(done),         32'd0);
    chk({tag, "_pass"},         32'(pass),         32'd0);
    chk({tag, "_halt_cause"},   32'(halt_cause),   32'd0);
    chk({tag, "_tohost_val"},   tohost_val,        32'd0);
    chk({tag, "_fail_idx"},     32'(fail_idx),     32'd0);
    chk({tag, "_mismatch_cnt"}, 32'(mismatch_cnt), 32'd0);
    chk({tag, "_cycle_count"},  cycle_count,       32'd0);
    chk({tag, "_rf_raddr"},     32'(rf_raddr),     32'd0);
  endtask

  task automatic default_checks();
    for (int i = 0; i < NC; i++) begin
      exp_idx[5*i +: 5]   = 5'(i);
      exp_val[32*i +: 32] = regs[i];
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    store_cyc = 0; store_data = '0; loop_cyc = 0;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    regs[1] = 32'ha;  regs[2] = 32'hf;  regs[3] = 32'h5;  regs[4] = 32'h14;
    regs[5] = 32'h14; regs[6] = 32'h65; regs[7] = 32'hc8;
    default_checks();
    repeat (3) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;
    @(negedge clk);

    // tohost store of 0x14 in run cycle 9, all expectations correct
    store_cyc = 9; store_data = 32'h14; loop_cyc = 0;
    run(mk(2'b01, 32'h14, 32'd9, 1'b1, 1'b1, 4'd0, 3'd0, 2 + 9 + NC + 1));
    wait_done();

    // j . at 0x2C reached in cycle 12: halt in cycle 14
    store_cyc = 0; loop_cyc = 12;
    run(mk(2'b10, 32'h0, 32'd14, 1'b1, 1'b1, 4'd0, 3'd0, 2 + 14 + NC + 1));
    wait_done();

    // checks 3 and 6 expect x10 = 0x12C, core holds 0
    exp_idx[5*3 +: 5] = 5'd10; exp_val[32*3 +: 32] = 32'h12C;
    exp_idx[5*6 +: 5] = 5'd10; exp_val[32*6 +: 32] = 32'h12C;
    store_cyc = 9; store_data = 32'h14; loop_cyc = 0;
    run(mk(2'b01, 32'h14, 32'd9, 1'b0, 1'b0, 4'd2, 3'd3, 2 + 9 + NC + 1));
    wait_done();
    default_checks();

    // endless non-repeating PC: timeout at 30
    store_cyc = 0; loop_cyc = 0;
    run(mk(2'b11, 32'h0, 32'd30, 1'b1, 1'b0, 4'd0, 3'd0, 2 + 30 + NC + 1));
    wait_done();

    // tohost store coincides with the timeout cycle
    store_cyc = 30; store_data = 32'h77;
    run(mk(2'b01, 32'h77, 32'd30, 1'b1, 1'b1, 4'd0, 3'd0, 2 + 30 + NC + 1));
    wait_done();

    // asynchronous reset in mid-run
    store_cyc = 9; store_data = 32'h14; loop_cyc = 0;
    run(mk(2'b01, 32'h14, 32'd9, 1'b1, 1'b1, 4'd0, 3'd0, 0));
    for (int i = 0; i < 100 && n_run < 5; i++) @(negedge clk);
    chk("reached_run5", 32'(n_run >= 5), 32'd1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_reset("midrun");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // clean rerun with start pulses during RUN and CHECK that must be ignored
    run(mk(2'b01, 32'h14, 32'd9, 1'b1, 1'b1, 4'd0, 3'd0, 2 + 9 + NC + 1));
    for (int i = 0; i < 100 && n_run < 4; i++) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && core_run; i++) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/riscv_run_monitor.md
# riscv_run_monitor

Synthesizable run controller and self-checker for the RISC-V cores. It sequences core reset, gates the core's clock enable, counts cycles, and detects program end: a tohost store, a PC self-loop, or a cycle budget. It then freezes the core and scans a parametrised list of expected register values through a register-file read port, reporting pass/fail. It replaces fixed-length run-and-dump benches, and the same block is used in simulation and on FPGA.

## Interface
- XLEN, 32, datapath width
- NUM_CHECKS, 8, number of (register index, expected value) pairs, ≥1
- CYCLE_LIMIT, 30, maximum RUN cycles, ≥1
- RESET_HOLD, 2, cycles core_rst_n is held low after start, ≥1
- HALT_REPEAT, 2, consecutive RUN cycles with unchanged PC that count as halt, ≥1
- TOHOST_ADDR, 32'h0000_0100, store address that signals program end
- TIMEOUT_FAILS, 0, 1 = reaching CYCLE_LIMIT forces fail

Ports:
- clk  in  1  clock, single domain
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE or DONE
- core_rst_n  out  1  active-low reset to the core
- core_run  out  1  clock enable to the core (PC, regfile and dmem writes)
- pc  in  XLEN  core's current PC
- dmem_we  in  1  core data-memory write enable
- dmem_addr  in  XLEN  core data-memory address
- dmem_wdata  in  XLEN  core data-memory write data
- exp_idx  in  5*NUM_CHECKS  packed register indices; entry i at [5i+4:5i]
- exp_val  in  XLEN*NUM_CHECKS  packed expected values; entry i at [XLEN*i+XLEN-1:XLEN*i]
- rf_raddr  out  5  register-file debug read address
- rf_rdata  in  XLEN  combinational debug read data for rf_raddr
- done  out  1  result valid
- pass  out  1  valid while done
- halt_cause  out  2  00 none, 01 tohost, 10 PC loop, 11 timeout
- tohost_val  out  XLEN  dmem_wdata captured on the tohost store
- fail_idx  out  clog2(NUM_CHECKS) (min 1)  index of the first mismatching check
- mismatch_cnt  out  clog2(NUM_CHECKS+1)  number of mismatching checks
- cycle_count  out  32  RUN cycles executed; saturates at 32'hFFFF_FFFF

## Operation
- States: IDLE, HOLD, RUN, CHECK, DONE.
- Reset (async): state is IDLE. core_rst_n=0, core_run=0, done=0, pass=0. halt_cause, tohost_val, fail_idx, mismatch_cnt, cycle_count and rf_raddr are all 0.
- IDLE: core held in reset. start moves to HOLD.
- HOLD: core_rst_n=0 for exactly RESET_HOLD cycles. On entry, all status outputs clear and done=0. Then RUN.
- RUN: core_rst_n=1, core_run=1, and cycle_count increments once per RUN cycle. Halt conditions, evaluated every RUN cycle:
  - tohost: dmem_we && dmem_addr==TOHOST_ADDR. Captures tohost_val.
  - PC loop: a same-PC counter increments when pc equals the previous cycle's pc and resets to 0 otherwise. The first RUN cycle performs no comparison. Halt when the counter reaches HALT_REPEAT.
  - timeout: the current RUN cycle is the CYCLE_LIMIT-th.
  - Priority when several hold in the same cycle: tohost > PC loop > timeout. halt_cause records the winner.
  - The halting cycle is the last core_run=1 cycle, so its store completes. Next state is CHECK.
- CHECK: core_rst_n=1, core_run=0, so core state is frozen. Check i runs in scan cycle i, for i = 0..NUM_CHECKS-1:
  - rf_raddr = exp_idx entry i.
  - Compare rf_rdata against exp_val entry i.
  - On a mismatch, increment mismatch_cnt. Load fail_idx only on the first mismatch.
  - Index 0 is legal and is compared normally (x0 reads 0).
  - After the last check, go to DONE.
- DONE: done=1. pass = (mismatch_cnt==0) && !(TIMEOUT_FAILS && halt_cause==11). core_run=0. Outputs hold until start (restart via HOLD) or reset.
- start outside IDLE/DONE is ignored.
- rst_n asserted mid-run aborts immediately into IDLE with reset values. core_rst_n drops asynchronously.

## Timing
- All outputs are registered. core_rst_n and core_run change on the clock edge of the state change.
- start sampled at edge E: core_rst_n rises at edge E+RESET_HOLD.
- Halt detected in RUN cycle k: CHECK begins the next cycle. done rises NUM_CHECKS+1 cycles after the halting edge.
- Total latency from start to done with a timeout halt: RESET_HOLD + CYCLE_LIMIT + NUM_CHECKS + 1 cycles.
- cycle_count is exact: it equals the number of core_run=1 cycles.

## Test plan
- Program ends with sw to 0x100 of 0x14 in RUN cycle 9, NUM_CHECKS=8, all expectations correct -> halt_cause=01, tohost_val=0x14, cycle_count=9, pass=1, mismatch_cnt=0.
- Program ends in `j .` at PC 0x2C, HALT_REPEAT=2 -> halt two cycles after PC first reaches 0x2C, halt_cause=10; core_run low from the next cycle; registers x1..x7 match 0xa, 0xf, 0x5, 0x14, 0x14, 0x65, 0xc8.
- Expected x10=0x12C but core holds 0 (checks 3 and 6 wrong) -> pass=0, fail_idx=3, mismatch_cnt=2.
- Endless non-repeating PC, CYCLE_LIMIT=30 -> halt_cause=11, cycle_count=30. Result is pass=1 with TIMEOUT_FAILS=0 and pass=0 with TIMEOUT_FAILS=1.
- tohost store and timeout in the same cycle -> halt_cause=01.
- rst_n low in RUN cycle 5, then start after release -> outputs return to reset values immediately; the rerun gives the same result as a clean run; start pulses during RUN/CHECK have no effect.
